character_data: RTL and testbench

Keyboard character accumulator for the Logo console front end. It accepts PS/2 set-2 make codes from the keyboard controller and converts each accepted code to ASCII. It keeps the four most recently typed characters as a 32-bit word for the command parser and display logic.

---
 rtl/character_data_pkg.sv | 15 +
 rtl/character_data_ps2_to_ascii.sv | 56 +++++
 rtl/character_data.sv | 62 ++++++
 tb/tb_character_data.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/character_data_pkg.sv
// Shared constants for the keyboard character accumulator: PS/2 set-2 scan
// codes of interest, the empty-slot marker and the window geometry.
package char_data_pkg;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_SPACE   = 8'h29;
    localparam logic [7:0] SC_BKSP    = 8'h66;
    localparam logic [7:0] ASCII_NONE = 8'h00;

    localparam int CHAR_SLOTS = 4;
    localparam int CHAR_W     = 8;
    localparam int WIN_W      = CHAR_SLOTS * CHAR_W;

endpackage

// File: rtl/character_data_ps2_to_ascii.sv
// Combinational PS/2 set-2 make code to uppercase ASCII lookup; o_valid marks
// codes that append a character (letters, main-row digits, space).
module ps2_to_ascii
    import char_data_pkg::*;
(
    input  logic [7:0] i_scan,
    output logic [7:0] o_ascii,
    output logic       o_valid
);

    always_comb begin
        o_ascii = ASCII_NONE;
        o_valid = 1'b1;
        case (i_scan)
            8'h1C: o_ascii = 8'h41; // A
            8'h32: o_ascii = 8'h42;
            8'h21: o_ascii = 8'h43;
            8'h23: o_ascii = 8'h44;
            8'h24: o_ascii = 8'h45;
            8'h2B: o_ascii = 8'h46;
            8'h34: o_ascii = 8'h47;
            8'h33: o_ascii = 8'h48;
            8'h43: o_ascii = 8'h49;
            8'h3B: o_ascii = 8'h4A;
            8'h42: o_ascii = 8'h4B;
            8'h4B: o_ascii = 8'h4C;
            8'h3A: o_ascii = 8'h4D;
            8'h31: o_ascii = 8'h4E;
            8'h44: o_ascii = 8'h4F;
            8'h4D: o_ascii = 8'h50;
            8'h15: o_ascii = 8'h51;
            8'h2D: o_ascii = 8'h52;
            8'h1B: o_ascii = 8'h53;
            8'h2C: o_ascii = 8'h54;
            8'h3C: o_ascii = 8'h55;
            8'h2A: o_ascii = 8'h56;
            8'h1D: o_ascii = 8'h57;
            8'h22: o_ascii = 8'h58;
            8'h35: o_ascii = 8'h59;
            8'h1A: o_ascii = 8'h5A; // Z
            8'h45: o_ascii = 8'h30; // 0
            8'h16: o_ascii = 8'h31;
            8'h1E: o_ascii = 8'h32;
            8'h26: o_ascii = 8'h33;
            8'h25: o_ascii = 8'h34;
            8'h2E: o_ascii = 8'h35;
            8'h36: o_ascii = 8'h36;
            8'h3D: o_ascii = 8'h37;
            8'h3E: o_ascii = 8'h38;
            8'h46: o_ascii = 8'h39; // 9
            SC_SPACE: o_ascii = 8'h20;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/character_data.sv
// Keyboard character accumulator: keeps the last four typed characters, newest
// in out[7:0]. Define CHARDATA_BACKSPACE_EN to make scan code 66 delete one.
module character_data
    import char_data_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        data_PS2key,
    input  logic              ctrl_PS2pressed,
    output logic [WIN_W-1:0]  out
);

    logic             r_prev;
    logic             r_break_pending;
    logic [WIN_W-1:0] r_window;

    logic             w_event;
    logic [7:0]       w_ascii;
    logic             w_valid;
    logic             w_bksp;

    ps2_to_ascii u_decode (
        .i_scan  (data_PS2key),
        .o_ascii (w_ascii),
        .o_valid (w_valid)
    );

    // r_prev resets high so a strobe already asserted at reset release is ignored.
    assign w_event = ctrl_PS2pressed & ~r_prev;

`ifdef CHARDATA_BACKSPACE_EN
    assign w_bksp = (data_PS2key == SC_BKSP);
`else
    assign w_bksp = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev          <= 1'b1;
            r_break_pending <= 1'b0;
            r_window        <= '0;
        end else begin
            r_prev <= ctrl_PS2pressed;
            if (w_event) begin
                if (r_break_pending) begin
                    r_break_pending <= 1'b0;
                end else if (data_PS2key == SC_BREAK) begin
                    r_break_pending <= 1'b1;
                end else if (data_PS2key == SC_EXT) begin
                    r_window <= r_window;
                end else if (w_valid) begin
                    r_window <= {r_window[WIN_W-CHAR_W-1:0], w_ascii};
                end else if (w_bksp) begin
                    r_window <= {ASCII_NONE, r_window[WIN_W-1:CHAR_W]};
                end
            end
        end
    end

    assign out = r_window;

endmodule

// File: tb/tb_character_data.sv
// Bench for character_data: random and directed key strobes, a queue-based
// reference model of the character window, and a monitor that checks every cycle.
`timescale 1ns/1ps
module tb_character_data;

  logic        clock;
  logic        reset;
  logic [7:0]  data_PS2key;
  logic        ctrl_PS2pressed;
  logic [31:0] out;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_cur;

  // reference model state
  logic [7:0] sc_map[logic [7:0]];
  logic [7:0] all_codes[$];
  logic [7:0] win_q[$];
  bit         m_brk;

  character_data dut (
    .clock           (clock),
    .reset           (reset),
    .data_PS2key     (data_PS2key),
    .ctrl_PS2pressed (ctrl_PS2pressed),
    .out             (out)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < win_q.size(); i++) w = {w[23:0], win_q[i]};
    return w;
  endfunction

  function automatic logic [31:0] model_apply(input logic [7:0] code);
    if (m_brk) begin
      m_brk = 1'b0;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else if (sc_map.exists(code)) begin
      win_q.push_back(sc_map[code]);
      if (win_q.size() > 4) void'(win_q.pop_front());
    end
`ifdef CHARDATA_BACKSPACE_EN
    else if (code == 8'h66) begin
      if (win_q.size() > 0) void'(win_q.pop_back());
    end
`endif
    return model_word();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: out=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic press(input logic [7:0] code, input int width, input int gap);
    @(negedge clock);
    data_PS2key     = code;
    ctrl_PS2pressed = 1'b1;
    exp_q.push_back(model_apply(code));
    for (int i = 1; i < width; i++) begin
      @(negedge clock);
      data_PS2key = 8'($urandom_range(0, 255));
    end
    @(negedge clock);
    ctrl_PS2pressed = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #3;
    reset = 1'b0;
    exp_q.delete();
    win_q.delete();
    m_brk   = 1'b0;
    exp_cur = 32'h0;
    #1;
    check("async_reset_clear", out, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // monitor / scoreboard
  initial begin
    bit tb_prev;
    bit ev;
    tb_prev = 1'b1;
    forever begin
      @(posedge clock);
      ev = 1'b0;
      if (!reset) begin
        tb_prev = 1'b1;
      end else begin
        ev      = ctrl_PS2pressed && !tb_prev;
        tb_prev = ctrl_PS2pressed;
      end
      @(negedge clock);
      if (reset) begin
        if (ev) begin
          if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_event: out=%08h expected=no event at %0t", out, $time);
          end else begin
            exp_cur = exp_q.pop_front();
            check("event", out, exp_cur);
          end
        end else begin
          check("hold", out, exp_cur);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [7:0] letters[26];
    logic [7:0] digits[10];
    logic [7:0] code;
    int         kind;
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 26; i++) begin
      sc_map[letters[i]] = 8'h41 + 8'(i);
      all_codes.push_back(letters[i]);
    end
    for (int i = 0; i < 10; i++) begin
      sc_map[digits[i]] = 8'h30 + 8'(i);
      all_codes.push_back(digits[i]);
    end
    sc_map[8'h29] = 8'h20;
    all_codes.push_back(8'h29);

    m_brk           = 1'b0;
    exp_cur         = 32'h0;
    reset           = 1'b0;
    ctrl_PS2pressed = 1'b0;
    data_PS2key     = 8'h00;
    #20;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_after_reset", out, 32'h0);

    press(8'h1C, 5, 2);   check("seq_A", out, 32'h00000041);
    press(8'h31, 3, 2);   check("seq_AN", out, 32'h0000414E);
    press(8'h23, 12, 2);  check("seq_AND", out, 32'h00414E44);
    press(8'h36, 12, 2);  check("seq_AND6", out, 32'h414E4436);
    press(8'h29, 1, 1);   check("space_drop_oldest", out, 32'h4E443620);
    press(8'hF0, 2, 1);   check("break_prefix", out, 32'h4E443620);
    press(8'h1C, 2, 1);   check("break_discard", out, 32'h4E443620);
    press(8'h32, 1, 1);   check("after_break_B", out, 32'h44362042);
    press(8'h76, 3, 1);   check("unmapped_76", out, 32'h44362042);
    press(8'hE0, 3, 1);   check("ext_E0", out, 32'h44362042);

    // strobe held high across reset release
    @(negedge clock);
    #3;
    reset = 1'b0;
    exp_q.delete();
    win_q.delete();
    m_brk   = 1'b0;
    exp_cur = 32'h0;
    #1;
    check("async_reset_mid_op", out, 32'h0);
    ctrl_PS2pressed = 1'b1;
    data_PS2key     = 8'h1C;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("held_strobe_ignored", out, 32'h0);
    ctrl_PS2pressed = 1'b0;
    @(negedge clock);
    press(8'h32, 2, 1);   check("after_reset_new_edge", out, 32'h00000042);

    do_reset();
    press(8'h1C, 1, 1);
    press(8'h31, 1, 1);
    press(8'h23, 1, 1);   check("bksp_start", out, 32'h00414E44);
    press(8'h66, 2, 1);
`ifdef CHARDATA_BACKSPACE_EN
    check("bksp_once", out, 32'h0000414E);
`else
    check("bksp_ignored", out, 32'h00414E44);
`endif
    press(8'h66, 1, 1);
    press(8'h66, 1, 1);
    press(8'h66, 1, 1);
`ifdef CHARDATA_BACKSPACE_EN
    check("bksp_empty", out, 32'h0);
`else
    check("bksp_ignored_x4", out, 32'h00414E44);
`endif
    press(8'h16, 1, 1);
    press(8'hF0, 1, 1);
    press(8'h66, 1, 1);
    press(8'h29, 1, 1);
`ifdef CHARDATA_BACKSPACE_EN
    check("break_then_bksp", out, 32'h00003120);
`else
    check("break_then_bksp", out, 32'h4E443120);
`endif

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        5:       code = 8'hF0;
        6:       code = 8'hE0;
        7:       code = 8'h66;
        8, 9:    code = 8'($urandom_range(0, 255));
        default: code = all_codes[$urandom_range(0, all_codes.size() - 1)];
      endcase
      press(code, $urandom_range(1, 4), $urandom_range(1, 3));
      if (n == 150) do_reset();
    end

    repeat (3) @(negedge clock);
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    check("final_model", out, model_word());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time=%0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
